// File: rtl/brancher_pkg.sv
// Shared definitions for the RV32I branch unit with dynamic prediction.
//   - Branch type encodings as driven by the control unit.
//   - 2-bit bimodal counter encodings.
//   - Helpers that split a PC into BHT/BTB index and tag.
package brancher_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BGE  = 3'b001;
    localparam logic [2:0] BR_BGEU = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BLTU = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Instructions are word aligned, so bits [1:0] never take part in indexing.
    function automatic logic [63:0] idx_of(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_cmp_rv32i.sv
// Combinational RV32I branch comparator.
//   branchtype : BEQ/BGE/BGEU/BLT/BLTU/BNE encoding (110/111 illegal)
//   in1, in2   : rs1 / rs2 operands
//   taken      : comparison result (0 for illegal types)
//   legal      : branchtype is one of the six defined encodings
module branch_cmp_rv32i
    import brancher_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branchtype,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (branchtype)
            BR_BEQ:  taken = (in1 == in2);
            BR_BNE:  taken = (in1 != in2);
            BR_BLT:  taken = ($signed(in1) <  $signed(in2));
            BR_BGE:  taken = ($signed(in1) >= $signed(in2));
            BR_BLTU: taken = (in1 <  in2);
            BR_BGEU: taken = (in1 >= in2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/brancher_pred_rv32i.sv
// Branch unit with bimodal direction prediction and a direct-mapped BTB.
//   Fetch side : if_pc -> pred_taken / pred_target (combinational lookup)
//   EX side    : ex_* inputs resolve the branch; ex_taken is combinational,
//                redirect_valid / redirect_pc are registered one cycle later
//   Stats      : branch_count / mispredict_count, saturating
//   clock / reset_n : rising-edge clock, asynchronous active-low reset
module brancher_pred_rv32i
    import brancher_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [2:0]      ex_branchtype,
    input  logic [XLEN-1:0] ex_in1,
    input  logic [XLEN-1:0] ex_in2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_pcnew,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [1:0]      ctr        [BHT_ENTRIES];
    logic            btb_valid  [BHT_ENTRIES];
    logic [TAG_W-1:0] btb_tag   [BHT_ENTRIES];
    logic [XLEN-1:0] btb_target [BHT_ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             btb_hit;
    logic             cmp_taken, cmp_legal;
    logic             resolve, mispredict;
    logic [31:0]      branch_cnt, mispred_cnt;

    assign if_idx = IDX_W'(idx_of(64'(if_pc), IDX_W));
    assign if_tag = TAG_W'(tag_of(64'(if_pc), IDX_W));
    assign ex_idx = IDX_W'(idx_of(64'(ex_pc), IDX_W));
    assign ex_tag = TAG_W'(tag_of(64'(ex_pc), IDX_W));

    // Lookup reads register state only, so a same-cycle update at this
    // index is not visible until after the edge.
    assign btb_hit     = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred_taken  = btb_hit && ctr[if_idx][1];
    assign pred_target = btb_hit ? btb_target[if_idx] : '0;

    branch_cmp_rv32i #(.XLEN(XLEN)) u_cmp (
        .branchtype (ex_branchtype),
        .in1        (ex_in1),
        .in2        (ex_in2),
        .taken      (cmp_taken),
        .legal      (cmp_legal)
    );

    assign resolve    = ex_valid && ex_branch && cmp_legal;
    assign ex_taken   = resolve && cmp_taken;
    // A taken branch with the right direction but a stale target still
    // fetched the wrong path.
    assign mispredict = resolve && ((ex_taken != ex_pred_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i]        <= CTR_INIT;
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (resolve) begin
            if (ex_taken) begin
                if (ctr[ex_idx] != ST)
                    ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                // Direct mapped: a taken branch always claims the entry.
                btb_valid[ex_idx]  <= 1'b1;
                btb_tag[ex_idx]    <= ex_tag;
                btb_target[ex_idx] <= ex_target;
            end else if (ctr[ex_idx] != SNT) begin
                ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict)
                redirect_pc <= ex_taken ? ex_target : ex_pcnew;
            if (resolve && (branch_cnt != 32'hFFFF_FFFF))
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF))
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign branch_count     = branch_cnt;
    assign mispredict_count = mispred_cnt;

endmodule

// File: tb/tb_brancher_pred_rv32i.sv
// Directed bench for brancher_pred_rv32i: comparator vector table plus
// hand-written multi-cycle sequences for training, aliasing, reset and
// counter saturation.
module tb_brancher_pred_rv32i;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic [2:0]  ex_branchtype = '0;
    logic [31:0] ex_in1 = '0, ex_in2 = '0, ex_pc = '0, ex_pcnew = '0, ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        ex_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_bc = '0, exp_mc = '0, exp_rpc = '0;

    always #5 clock = ~clock;

    brancher_pred_rv32i #(.XLEN(32), .BHT_ENTRIES(64), .CTR_INIT(2'b01)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_branchtype    (ex_branchtype),
        .ex_in1           (ex_in1),
        .ex_in2           (ex_in2),
        .ex_pc            (ex_pc),
        .ex_pcnew         (ex_pcnew),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_taken         (ex_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One EX-stage branch; exp_t is the hand-computed compare outcome.
    task automatic do_branch(input string nm, input logic [2:0] bt,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pt, input logic [31:0] ptgt,
                             input logic v, input logic exp_t);
        logic res, mis;
        @(negedge clock);
        ex_valid = v; ex_branch = 1'b1; ex_branchtype = bt;
        ex_in1 = a; ex_in2 = b; ex_pc = pc; ex_pcnew = pc + 32'd4; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        res = v && (bt < 3'b110);
        mis = res && ((exp_t != pt) || (exp_t && (ptgt != tgt)));
        #1 chk({nm, " ex_taken"}, 32'(ex_taken), 32'(res && exp_t));
        @(posedge clock);
        #1;
        if (res && exp_bc != 32'hFFFF_FFFF) exp_bc++;
        if (mis && exp_mc != 32'hFFFF_FFFF) exp_mc++;
        if (mis) exp_rpc = exp_t ? tgt : pc + 32'd4;
        chk({nm, " redirect_valid"}, 32'(redirect_valid), 32'(mis));
        chk({nm, " redirect_pc"}, redirect_pc, exp_rpc);
        chk({nm, " branch_count"}, branch_count, exp_bc);
        chk({nm, " mispredict_count"}, mispredict_count, exp_mc);
        ex_valid = 1'b0; ex_branch = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  bt;
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
        logic        br;
        logic        exp;
    } vec_t;

    vec_t vecs[16];
    logic [1:0] ectr[9];
    logic prev_pred;

    initial begin
        vecs[0]  = '{3'b000, 32'd5,         32'd5, 1'b1, 1'b1, 1'b1}; // BEQ eq
        vecs[1]  = '{3'b000, 32'd5,         32'd6, 1'b1, 1'b1, 1'b0}; // BEQ ne
        vecs[2]  = '{3'b101, 32'd5,         32'd6, 1'b1, 1'b1, 1'b1}; // BNE ne
        vecs[3]  = '{3'b101, 32'd7,         32'd7, 1'b1, 1'b1, 1'b0}; // BNE eq
        vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b1}; // BLT -1<1
        vecs[5]  = '{3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0}; // BLTU big<1
        vecs[6]  = '{3'b001, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0}; // BGE -1>=1
        vecs[7]  = '{3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b1}; // BGEU
        vecs[8]  = '{3'b001, 32'd3,         32'd3, 1'b1, 1'b1, 1'b1}; // BGE eq
        vecs[9]  = '{3'b011, 32'd3,         32'd3, 1'b1, 1'b1, 1'b0}; // BLT eq
        vecs[10] = '{3'b010, 32'd0,         32'd1, 1'b1, 1'b1, 1'b0}; // BGEU 0>=1
        vecs[11] = '{3'b100, 32'd0,         32'd1, 1'b1, 1'b1, 1'b1}; // BLTU 0<1
        vecs[12] = '{3'b110, 32'd5,         32'd5, 1'b1, 1'b1, 1'b0}; // illegal
        vecs[13] = '{3'b111, 32'd5,         32'd5, 1'b1, 1'b1, 1'b0}; // illegal
        vecs[14] = '{3'b000, 32'd5,         32'd5, 1'b0, 1'b1, 1'b0}; // bubble
        vecs[15] = '{3'b000, 32'd5,         32'd5, 1'b1, 1'b0, 1'b0}; // not branch
        ectr = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};

        // Reset state
        if_pc = 32'h100;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst pred_taken", 32'(pred_taken), 32'd0);
        chk("rst pred_target", pred_target, 32'd0);
        chk("rst branch_count", branch_count, 32'd0);
        chk("rst mispredict_count", mispredict_count, 32'd0);
        chk("rst redirect_valid", 32'(redirect_valid), 32'd0);

        // Comparator table; EX inputs drop before each edge so no state changes
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            ex_valid = vecs[i].v; ex_branch = vecs[i].br; ex_branchtype = vecs[i].bt;
            ex_in1 = vecs[i].a; ex_in2 = vecs[i].b; ex_pc = 32'h300;
            #1 chk($sformatf("vec%0d ex_taken", i), 32'(ex_taken), 32'(vecs[i].exp));
            ex_valid = 1'b0; ex_branch = 1'b0;
        end
        @(posedge clock); #1;
        chk("table no count", branch_count, 32'd0);

        // First taken BEQ allocates the BTB and redirects
        do_branch("beq1", 3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("beq1 ctr", 32'(dut.ctr[0]), 32'd2);
        chk("beq1 pred_taken", 32'(pred_taken), 32'd1);
        chk("beq1 pred_target", pred_target, 32'h140);
        @(posedge clock); #1;
        chk("beq1 redirect drops", 32'(redirect_valid), 32'd0);
        chk("beq1 redirect_pc holds", redirect_pc, 32'h140);

        // BLTU -1 vs 1 not taken although predicted taken -> fall through
        do_branch("bltu", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h140, 1'b1, 32'h140, 1'b1, 1'b0);
        chk("bltu ctr", 32'(dut.ctr[0]), 32'd1);
        chk("bltu pred_taken", 32'(pred_taken), 32'd0);

        // Counter training: four taken then five not-taken
        prev_pred = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_branch($sformatf("train%0d", i), 3'b000, 32'd5, (i < 4) ? 32'd5 : 32'd6,
                      32'h100, 32'h140, prev_pred, 32'h140, 1'b1, i < 4);
            chk($sformatf("train%0d ctr", i), 32'(dut.ctr[0]), 32'(ectr[i]));
            chk($sformatf("train%0d pred", i), 32'(pred_taken), 32'(ectr[i][1]));
            prev_pred = ectr[i][1];
        end

        // Aliasing: 0x100 and 0x200 share index 0 with different tags
        do_branch("alias_a", 3'b000, 32'd1, 32'd1, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 1'b1);
        do_branch("alias_b", 3'b000, 32'd1, 32'd1, 32'h200, 32'h240, 1'b0, 32'h0, 1'b1, 1'b1);
        if_pc = 32'h100; #1;
        chk("alias old pred_taken", 32'(pred_taken), 32'd0);
        chk("alias old pred_target", pred_target, 32'd0);
        if_pc = 32'h200; #1;
        chk("alias new pred_taken", 32'(pred_taken), 32'd1);
        chk("alias new pred_target", pred_target, 32'h240);

        // Illegal type and bubble: no update, count or redirect
        do_branch("illegal", 3'b110, 32'd1, 32'd1, 32'h200, 32'h280, 1'b0, 32'h0, 1'b1, 1'b1);
        do_branch("bubble", 3'b000, 32'd1, 32'd2, 32'h200, 32'h280, 1'b1, 32'h240, 1'b0, 1'b0);
        chk("no-update ctr", 32'(dut.ctr[0]), 32'd2);
        chk("no-update pred_target", pred_target, 32'h240);

        // Reset in the redirect cycle
        do_branch("pre_rst", 3'b101, 32'd1, 32'd1, 32'h200, 32'h240, 1'b1, 32'h240, 1'b1, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst redirect_valid", 32'(redirect_valid), 32'd0);
        chk("midrst redirect_pc", redirect_pc, 32'd0);
        chk("midrst branch_count", branch_count, 32'd0);
        chk("midrst mispredict_count", mispredict_count, 32'd0);
        chk("midrst pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst ctr", 32'(dut.ctr[0]), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        exp_bc = '0; exp_mc = '0; exp_rpc = '0;

        // Saturation of both counters
        @(negedge clock);
        force dut.branch_cnt = 32'hFFFF_FFFE;
        force dut.mispred_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.branch_cnt;
        release dut.mispred_cnt;
        exp_bc = 32'hFFFF_FFFE; exp_mc = 32'hFFFF_FFFE;
        do_branch("sat1", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h480, 1'b0, 32'h0, 1'b1, 1'b1);
        do_branch("sat2", 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h490, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("sat branch_count", branch_count, 32'hFFFF_FFFF);
        chk("sat mispredict_count", mispredict_count, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
